// File: rtl/field_pkg.sv
// Shared definitions for the snake game field and step controller:
// cell codes, controller state encoding and field sizing helpers.
package field_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SNAKE = 2'b01;
    localparam logic [1:0] CELL_APPLE = 2'b10;
    localparam logic [1:0] CELL_BLOCK = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_TICK   = 3'd1;
    localparam state_t ST_MOVE   = 3'd2;
    localparam state_t ST_UPDATE = 3'd3;
    localparam state_t ST_PLACE  = 3'd4;
    localparam state_t ST_OVER   = 3'd5;

    function automatic int unsigned cells_n(input int unsigned sx,
                                            input int unsigned sy);
        return sx * sy;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rand_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
module rand_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Reload the seed should the register ever be found stuck at zero.
    always_comb begin
        q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
        if (q_q == 8'h00) begin
            q_d = SEED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/game_step_ctrl.sv
// Game tick sequencer: paces snake moves, field redraws and apple
// placement, and keeps the score / game-over / win state.
module game_step_ctrl
    import field_pkg::*;
#(
    parameter int unsigned SIZE_X    = 10,
    parameter int unsigned SIZE_Y    = 10,
    parameter int unsigned TICK_DIV  = 50000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    localparam int unsigned N          = cells_n(SIZE_X, SIZE_Y),
    localparam int unsigned IDX_W      = idx_w(N),
    localparam int unsigned FIELD_SIZE = 2 * N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  snake_done,
    input  logic                  hit,
    input  logic                  ate,
    input  logic [FIELD_SIZE-1:0] field,
    output logic                  snake_step,
    output logic                  field_step,
    output logic                  apple_we,
    output logic [IDX_W-1:0]      apple_idx,
    output logic [15:0]           score,
    output logic                  game_over,
    output logic                  win
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   N_EXT     = (IDX_W + 1)'(N);
    localparam logic [IDX_W:0]   TRY_LAST  = (IDX_W + 1)'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] probe_q, probe_d;
    logic [IDX_W:0]   tries_q, tries_d;
    logic             ate_q, ate_d;
    logic [15:0]      score_q, score_d;
    logic             win_q, win_d;
    logic             over_q, over_d;
    logic             snake_step_q, snake_step_d;
    logic             field_step_q, field_step_d;
    logic             apple_we_q, apple_we_d;
    logic [IDX_W-1:0] apple_idx_q, apple_idx_d;

    logic [7:0]       lfsr_q;
    logic [IDX_W:0]   rand_ext;
    logic [IDX_W-1:0] start_idx;
    logic [1:0]       cell_cur;
    logic             unused_lfsr;

    rand_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q;

    // 2^IDX_W < 2N, so one conditional subtraction folds r into 0..N-1.
    assign rand_ext  = {1'b0, lfsr_q[IDX_W-1:0]};
    assign start_idx = (rand_ext >= N_EXT) ? IDX_W'(rand_ext - N_EXT)
                                           : lfsr_q[IDX_W-1:0];

    assign cell_cur = field[{probe_q, 1'b0} +: 2];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        probe_d      = probe_q;
        tries_d      = tries_q;
        ate_d        = ate_q;
        score_d      = score_q;
        win_d        = win_q;
        apple_idx_d  = apple_idx_q;
        snake_step_d = 1'b0;
        field_step_d = 1'b0;
        apple_we_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    score_d = '0;
                    win_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_TICK;
                end
            end
            ST_TICK: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    snake_step_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_MOVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MOVE: begin
                if (snake_done) begin
                    if (hit) begin
                        state_d = ST_OVER;
                    end else begin
                        ate_d        = ate;
                        field_step_d = 1'b1;
                        state_d      = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                if (ate_q) begin
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                    probe_d = start_idx;
                    tries_d = '0;
                    state_d = ST_PLACE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_TICK;
                end
            end
            ST_PLACE: begin
                if (cell_cur == CELL_EMPTY) begin
                    apple_idx_d = probe_q;
                    apple_we_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_TICK;
                end else begin
                    probe_d = (probe_q == IDX_LAST) ? '0
                                                    : probe_q + 1'b1;
                    tries_d = tries_q + 1'b1;
                    if (tries_q == TRY_LAST) begin
                        win_d   = 1'b1;
                        state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            probe_q      <= '0;
            tries_q      <= '0;
            ate_q        <= 1'b0;
            score_q      <= '0;
            win_q        <= 1'b0;
            over_q       <= 1'b0;
            snake_step_q <= 1'b0;
            field_step_q <= 1'b0;
            apple_we_q   <= 1'b0;
            apple_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            probe_q      <= probe_d;
            tries_q      <= tries_d;
            ate_q        <= ate_d;
            score_q      <= score_d;
            win_q        <= win_d;
            over_q       <= over_d;
            snake_step_q <= snake_step_d;
            field_step_q <= field_step_d;
            apple_we_q   <= apple_we_d;
            apple_idx_q  <= apple_idx_d;
        end
    end

    assign snake_step = snake_step_q;
    assign field_step = field_step_q;
    assign apple_we   = apple_we_q;
    assign apple_idx  = apple_idx_q;
    assign score      = score_q;
    assign game_over  = over_q;
    assign win        = win_q;

endmodule

// File: tb/tb_game_step_ctrl.sv
// Scoreboard bench for game_step_ctrl on a 4x4 field, TICK_DIV=4.
module tb_game_step_ctrl;

    localparam int EV_SNAKE = 0;
    localparam int EV_FIELD = 1;
    localparam int EV_APPLE = 2;
    localparam int EV_OVER  = 3;

    typedef struct {
        int kind;
        int at;
        int idx;
        int score;
        bit over;
        bit win;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        snake_done;
    logic        hit;
    logic        ate;
    logic [31:0] field;
    logic        snake_step;
    logic        field_step;
    logic        apple_we;
    logic [3:0]  apple_idx;
    logic [15:0] score;
    logic        game_over;
    logic        win;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] lm;
    logic       go_prev = 1'b0;

    game_step_ctrl #(
        .SIZE_X    (4),
        .SIZE_Y    (4),
        .TICK_DIV  (4),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .snake_done (snake_done),
        .hit        (hit),
        .ate        (ate),
        .field      (field),
        .snake_step (snake_step),
        .field_step (field_step),
        .apple_we   (apple_we),
        .apple_idx  (apple_idx),
        .score      (score),
        .game_over  (game_over),
        .win        (win)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference copy of the start-index generator.
    always @(posedge clk or posedge rst) begin
        if (rst) lm <= 8'hA5;
        else     lm <= lfsr_nx(lm);
    end

    task automatic check_eq(input string name, input longint act,
                            input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic expect_ev(input int kind, input int at, input int idx,
                             input int sc, input bit ov, input bit w);
        ev_t e;
        e.kind  = kind;
        e.at    = at;
        e.idx   = idx;
        e.score = sc;
        e.over  = ov;
        e.win   = w;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        int   kind;
        ev_t  e;
        bit   ok;
        if (rst) begin
            go_prev = 1'b0;
        end else begin
            kind = -1;
            if (snake_step)                 kind = EV_SNAKE;
            else if (field_step)            kind = EV_FIELD;
            else if (apple_we)              kind = EV_APPLE;
            else if (game_over && !go_prev) kind = EV_OVER;
            go_prev = game_over;
            if (kind >= 0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected event: got kind=%0d at %0d, want none",
                             kind, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (kind == e.kind) && (cyc == e.at) &&
                         (score == 16'(e.score)) && (game_over == e.over) &&
                         (win == e.win) &&
                         (e.kind != EV_APPLE || apple_idx == 4'(e.idx));
                    if (ok) n_pass++;
                    else $display({"FAIL event: got kind=%0d cyc=%0d idx=%0d ",
                                   "score=%0d over=%0b win=%0b, want kind=%0d ",
                                   "cyc=%0d idx=%0d score=%0d over=%0b win=%0b"},
                                  kind, cyc, apple_idx, score, game_over, win,
                                  e.kind, e.at, e.idx, e.score, e.over, e.win);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic do_move(input logic h, input logic a);
        snake_done = 1'b1;
        hit        = h;
        ate        = a;
        step(1);
        snake_done = 1'b0;
        hit        = 1'b0;
        ate        = 1'b0;
    endtask

    // Hold in MOVE until the index loaded in UPDATE will be `want`.
    task automatic wait_start(input int want);
        int         k = 0;
        logic [7:0] nx;
        logic [3:0] w4;
        w4 = 4'(want);
        nx = lfsr_nx(lm);
        while (nx[3:0] != w4 && k < 400) begin
            step(1);
            k++;
            nx = lfsr_nx(lm);
        end
        check_eq("start idx wait", nx[3:0], w4);
    endtask

    initial begin
        int t;
        rst        = 1'b1;
        run        = 1'b0;
        snake_done = 1'b0;
        hit        = 1'b0;
        ate        = 1'b0;
        field      = '0;
        step(1);
        check_eq("rst snake_step", snake_step, 0);
        check_eq("rst field_step", field_step, 0);
        check_eq("rst apple_we", apple_we, 0);
        check_eq("rst apple_idx", apple_idx, 0);
        check_eq("rst score", score, 0);
        check_eq("rst game_over", game_over, 0);
        check_eq("rst win", win, 0);
        step(1);
        rst = 1'b0;
        step(2);

        // tick, no eat
        t = cyc;
        run = 1'b1;
        expect_ev(EV_SNAKE, t + 5, 0, 0, 0, 0);
        goto_cyc(t + 5);
        t = cyc;
        expect_ev(EV_FIELD, t + 1, 0, 0, 0, 0);
        expect_ev(EV_SNAKE, t + 6, 0, 0, 0, 0);
        do_move(1'b0, 1'b0);
        goto_cyc(t + 6);

        // eat, start cell 5 free
        field = {16{2'b01}};
        field[10 +: 2] = 2'b00;
        wait_start(5);
        t = cyc;
        expect_ev(EV_FIELD, t + 1, 0, 0, 0, 0);
        expect_ev(EV_APPLE, t + 3, 5, 1, 0, 0);
        expect_ev(EV_SNAKE, t + 7, 0, 1, 0, 0);
        do_move(1'b0, 1'b1);
        goto_cyc(t + 7);

        // eat, probe wraps 14,15,0 -> 1
        field = {16{2'b01}};
        field[2 +: 2] = 2'b00;
        wait_start(14);
        t = cyc;
        expect_ev(EV_FIELD, t + 1, 0, 1, 0, 0);
        expect_ev(EV_APPLE, t + 6, 1, 2, 0, 0);
        expect_ev(EV_SNAKE, t + 10, 0, 2, 0, 0);
        do_move(1'b0, 1'b1);
        goto_cyc(t + 10);

        // collision with ate also set
        t = cyc;
        expect_ev(EV_OVER, t + 1, 0, 2, 1, 0);
        do_move(1'b1, 1'b1);
        step(2);
        check_eq("hit game_over", game_over, 1);
        run = 1'b0;
        step(1);
        check_eq("over->idle game_over", game_over, 0);
        check_eq("over->idle score hold", score, 2);
        t = cyc;
        run = 1'b1;
        expect_ev(EV_SNAKE, t + 5, 0, 0, 0, 0);
        step(1);
        check_eq("restart score", score, 0);
        goto_cyc(t + 5);

        // full field: every probe fails
        field = {16{2'b01}};
        t = cyc;
        expect_ev(EV_FIELD, t + 1, 0, 0, 0, 0);
        expect_ev(EV_OVER, t + 18, 0, 1, 1, 1);
        do_move(1'b0, 1'b1);
        goto_cyc(t + 18);
        step(2);
        check_eq("full game_over", game_over, 1);
        check_eq("full win", win, 1);
        run = 1'b0;
        step(1);
        check_eq("full idle game_over", game_over, 0);
        check_eq("full idle win hold", win, 1);
        check_eq("full idle score hold", score, 1);
        t = cyc;
        run = 1'b1;
        expect_ev(EV_SNAKE, t + 5, 0, 0, 0, 0);
        step(1);
        check_eq("rerun win", win, 0);
        check_eq("rerun score", score, 0);
        goto_cyc(t + 5);

        // async reset while probing
        t = cyc;
        expect_ev(EV_FIELD, t + 1, 0, 0, 0, 0);
        do_move(1'b0, 1'b1);
        step(3);
        check_eq("pre-rst score", score, 1);
        #2;
        rst = 1'b1;
        run = 1'b0;
        #1;
        check_eq("async score", score, 0);
        check_eq("async apple_idx", apple_idx, 0);
        check_eq("async apple_we", apple_we, 0);
        check_eq("async game_over", game_over, 0);
        check_eq("async win", win, 0);
        @(negedge clk);
        rst = 1'b0;
        step(10);
        check_eq("idle snake_step", snake_step, 0);
        check_eq("pending events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_step_ctrl.md
# game_step_ctrl

Sequencing controller for the snake game datapath. It divides the clock into game ticks and pulses the snake-move logic on each tick. It then pulses the field update, and after an eat event chooses a free cell and commands an apple write into the field. It sits between the snake logic and the field register array. It owns the game-over and score state.

## Interface
- SIZE_X, 10, field width in cells
- SIZE_Y, 10, field height in cells
- TICK_DIV, 50000, clocks per game tick (≥2)
- LFSR_SEED, 8'hA5, nonzero LFSR reset value
- derived: N = SIZE_X*SIZE_Y (≤128), IDX_W = $clog2(N), FIELD_SIZE = 2*N

- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = game enabled
- snake_done  in  1  pulse; snake logic finished move
- hit  in  1  valid with snake_done; head hit body or wall
- ate  in  1  valid with snake_done; head landed on apple
- field  in  FIELD_SIZE  cell i at [2i+1:2i]; 00 empty, 01 snake, 10 apple, 11 block
- snake_step  out  1  one-cycle pulse: perform move
- field_step  out  1  one-cycle pulse: redraw snake into field
- apple_we  out  1  one-cycle pulse: write apple at apple_idx
- apple_idx  out  IDX_W  cell index, i = x + y*SIZE_X
- score  out  16  apples eaten this game
- game_over  out  1  level
- win  out  1  level; game over because field full

## Operation
- FSM states: IDLE, TICK, MOVE, UPDATE, PLACE, OVER.
- IDLE: all pulses 0. On run=1: clear score, win, and tick counter; go to TICK.
- TICK: counter counts 0..TICK_DIV-1. At the terminal count, assert snake_step for one cycle, clear the counter, and go to MOVE. If run=0, go to IDLE; this check has priority over the terminal count.
- MOVE: wait for snake_done.
  - hit=1 with it → OVER. hit has priority over ate.
  - Otherwise latch ate, pulse field_step, and go to UPDATE.
  - run is ignored in this state; the move always completes.
- UPDATE: one settle cycle so the field registers reflect the move. If latched ate, then score+1 (saturates at 16'hFFFF), load probe = start index, clear attempts, and go to PLACE. Otherwise go to TICK.
- PLACE: each cycle examine field cell[probe].
  - Empty (00): apple_idx=probe, pulse apple_we, go to TICK.
  - Not empty: probe = (probe==N-1) ? 0 : probe+1; attempts+1.
  - If attempts reaches N without finding an empty cell: win=1, go to OVER.
- OVER: game_over=1. Hold until run=0, then go to IDLE. score and win hold until the next run.
- Start index: take r = lfsr[IDX_W-1:0]. Use r-N if r≥N, else r. One subtraction suffices because 2^IDX_W < 2N.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Free-running every clock, including in IDLE. Never all-zero.

## Timing
- Reset values:
  - state IDLE, counter 0, lfsr LFSR_SEED
  - snake_step 0, field_step 0, apple_we 0, apple_idx 0
  - score 0, game_over 0, win 0
- All outputs are registered; no combinational input→output path.
- Tick period is exactly TICK_DIV clocks from TICK entry to the snake_step pulse, excluding move/update/place time.
- snake_done→field_step: 1 cycle.
- field_step→UPDATE decision: 1 cycle.
- PLACE: 1 cycle per probe. Worst case N cycles, then OVER.
- apple_idx is stable from the apple_we cycle until the next apple_we.
- snake_done is ignored outside MOVE.
- rst mid-operation: immediate return to the reset values; no pulse completes.
- run falling in PLACE: placement completes first, then TICK sees run=0 and goes to IDLE.

## Structure
- Shared package field_pkg holds:
  - cell codes CELL_EMPTY/SNAKE/APPLE/BLOCK (2 bits)
  - state enum
  - N, IDX_W helper functions
- Sub-module rand_lfsr8 (clk, rst, seed param, 8-bit q) holds the LFSR.
- FSM, counter and probe logic stay in game_step_ctrl.

## Test plan
Benches use SIZE_X=4, SIZE_Y=4 (N=16), TICK_DIV=4.
- Tick/no eat: run=1 after reset → snake_step after 4 clks. snake_done (ate=0) → field_step next cycle, then back to TICK. No apple_we; score stays 0.
- Eat, first cell free: LFSR start index 5, cell 5 = 00 → apple_we with apple_idx=5 two cycles after field_step (UPDATE, then PLACE); score=1.
- Probe with wrap: start index 14, cells 14, 15, 0 snake, cell 1 empty → apple_we at idx 1 after 4 PLACE cycles.
- Full field: all cells 01 on eat → 16 PLACE cycles, then game_over=1, win=1, no apple_we. run=0 → IDLE; run=1 → score=0, win=0.
- Collision: snake_done with hit=1 and ate=1 → OVER, no field_step, score unchanged.
- Async reset mid-PLACE: rst asserted between clocks → outputs return to reset values immediately. After release, an idle run=0 produces no pulses.
